// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - three-port round-robin arbiter for an asynchronous 16-bit SRAM
module sram_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [47:0]         wdata,
    output logic [2:0]          ack,
    output logic [15:0]         rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   sram_addr,
    inout  wire  [15:0]         sram_data,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } stateT;

    // ACCESS lasts WAIT_CYCLES cycles: the counter is loaded with one less and
    // the last ACCESS cycle is the one that sees zero.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    stateT             state;
    stateT             stateNext;
    logic [3:0]        waitCnt;
    logic [1:0]        lastGrant;
    logic [1:0]        curPort;
    logic [1:0]        grantPort;
    logic              grantValid;
    logic [ADDR_W-1:0] curAddr;
    logic              curWe;
    logic [15:0]       curWdata;
    logic              driveBus;

    // Ports are numbered 0..2; anything past 2 wraps to port 0.
    function automatic logic [1:0] nextPort(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Round-robin pick: first requesting port found starting after the last winner.
    always_comb begin
        logic [1:0] cand;
        grantValid = 1'b0;
        grantPort  = 2'd0;
        cand       = nextPort(lastGrant);
        for (int k = 0; k < 3; k++) begin
            if (!grantValid && req[cand]) begin
                grantValid = 1'b1;
                grantPort  = cand;
            end
            cand = nextPort(cand);
        end
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Grant latching, wait counter and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt   <= 4'd0;
            lastGrant <= 2'd2;
            curPort   <= 2'd0;
            curAddr   <= '0;
            curWe     <= 1'b0;
            curWdata  <= 16'd0;
            rdata     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        lastGrant <= grantPort;
                        curPort   <= grantPort;
                        curAddr   <= addr[int'(grantPort)*ADDR_W +: ADDR_W];
                        curWe     <= we[grantPort];
                        curWdata  <= wdata[int'(grantPort)*16 +: 16];
                    end
                end
                SETUP: begin
                    waitCnt <= WAIT_LOAD;
                end
                ACCESS: begin
                    if (waitCnt != 4'd0) begin
                        waitCnt <= waitCnt - 4'd1;
                    end else if (!curWe) begin
                        rdata <= sram_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state sequencing: IDLE -> SETUP -> ACCESS (counted) -> HOLD -> IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grantValid) stateNext = SETUP;
            SETUP:   stateNext = ACCESS;
            ACCESS:  if (waitCnt == 4'd0) stateNext = HOLD;
            HOLD:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // SRAM strobes, address, bus enable and ack decoded from state so reset forces them off at once.
    always_comb begin
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_addr = '0;
        ack       = 3'b000;
        driveBus  = 1'b0;
        case (state)
            SETUP: begin
                sram_ce_n = 1'b0;
                sram_addr = curAddr;
                sram_oe_n = curWe;
                driveBus  = curWe;
            end
            ACCESS: begin
                sram_ce_n = 1'b0;
                sram_addr = curAddr;
                sram_oe_n = curWe;
                sram_we_n = !curWe;
                driveBus  = curWe;
            end
            HOLD: begin
                sram_ce_n = 1'b0;
                sram_addr = curAddr;
                driveBus  = curWe;
                ack       = 3'b001 << curPort;
            end
            default: begin
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign sram_data = driveBus ? curWdata : 16'hzzzz;

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, 1, number of ACCESS-state cycles per SRAM transaction; legal range 1..15.
REQ-002 Parameter: ADDR_W, 18, SRAM word-address width.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req  in  3  per-port request; bit0 = data port, bit1 = fetch port, bit2 = video port.
REQ-006 we  in  3  per-port write enable (1 = write); sampled with req.
REQ-007 addr  in  3*ADDR_W  per-port word address, port n at bits [n*ADDR_W +: ADDR_W].
REQ-008 wdata  in  48  per-port write data, port n at bits [n*16 +: 16].
REQ-009 ack  out  3  per-port one-cycle completion pulse.
REQ-010 rdata  out  16  read data, shared by all ports; valid while the matching ack is high.
REQ-011 busy  out  1  high whenever the state is not IDLE.
REQ-012 sram_addr  out  ADDR_W  SRAM address.
REQ-013 sram_data  inout  16  SRAM data bus.
REQ-014 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-015 The FSM SHALL use four states: IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles, 4-bit down-counter) -> HOLD (1 cycle) -> IDLE.
REQ-016 In IDLE, with any req bit high at a clock edge, the block SHALL grant exactly one port and move to SETUP.
- Grant is round-robin: search starts at last_grant+1 mod 3.
- last_grant updates on every grant.
REQ-017 On grant, the block SHALL latch the winner's addr, we and wdata; the requester's inputs need not stay stable after the grant edge.
REQ-018 In SETUP, ACCESS and HOLD, the block SHALL drive sram_addr = latched address and sram_ce_n = 0.
REQ-019 Read strobes: sram_oe_n = 0 in SETUP and ACCESS, 1 in HOLD; sram_we_n stays 1 throughout.
REQ-020 Write strobes:
- sram_data driven with latched wdata in SETUP, ACCESS and HOLD.
- sram_we_n = 0 only in ACCESS.
- sram_oe_n stays 1.
REQ-021 sram_data SHALL be high-Z in IDLE and for the whole of every read.
REQ-022 For reads, rdata SHALL capture sram_data on the edge leaving ACCESS; rdata holds until the next read capture, and writes leave it unchanged.
REQ-023 ack[granted port] SHALL be high during HOLD only; all other ack bits stay 0.
- Latency: grant edge to ack = WAIT_CYCLES+2 cycles.
REQ-024 Requester handshake:
- A requester SHALL drop req in the cycle after it samples ack high.
- req still high in that IDLE cycle is a new request.
REQ-025 Deasserting req after the grant SHALL NOT abort the transaction; the ack still pulses.
REQ-026 Two transactions SHALL be separated by at least one IDLE cycle, with all strobes high during that cycle.
REQ-027 req is not sampled outside IDLE; pending requests wait without loss for as long as they are held.
REQ-028 busy SHALL be combinational from state: 1 in SETUP, ACCESS and HOLD.

Reset
REQ-029 When rst = 0, the block SHALL immediately and asynchronously enter this state, including mid-transaction:
- state = IDLE, busy = 0.
- sram_ce_n = sram_oe_n = sram_we_n = 1, sram_data high-Z, sram_addr = 0.
- ack = 0, rdata = 0, wait counter = 0.
- last_grant = 2, so port 0 wins first.
REQ-030 A transaction cut off by reset SHALL produce no ack; requesters re-request after reset is released.

Verification
REQ-031 The bench SHALL cover these scenarios (WAIT_CYCLES = 1 unless stated):
- Single read: port1 reads 0x00123, SRAM model returns 0xBEEF -> ack[1] 3 cycles after grant edge; rdata = 0xBEEF; oe_n low 2 cycles; we_n never low.
- Single write: port0 writes 0xA5A5 to 0x3FFFF -> we_n low exactly 1 cycle; bus driven 0xA5A5 for 3 cycles, high-Z before and after; model holds 0xA5A5; ack[0] pulses once.
- Fairness: all three req held high from reset -> grant order 0,1,2,0,1,2; no port granted twice while another is pending.
- Reset mid-write: rst asserted during ACCESS -> same-cycle strobes high and bus high-Z; no ack; after release, first grant goes to port 0.
- Wait states and early drop: WAIT_CYCLES = 3, port2 read with req dropped during SETUP -> ack[2] 5 cycles after grant edge; oe_n low 4 cycles; correct rdata.
- Back-to-back: port2 reasserts req in the IDLE cycle right after its ack -> new grant at the end of that IDLE cycle; exactly one strobe-free cycle between the two transactions.
